// File: rtl/stage_sequencer_pkg.sv
// ============================================================================
// Module   : stage_sequencer_pkg
// Purpose  : Shared state encoding and default parameters for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_sequencer_pkg;

    localparam int c_num_stages_dflt         = 5;
    localparam int c_mem_stage_dflt          = 3;
    localparam int c_reset_clear_cycles_dflt = 2;
    localparam int c_counter_width_dflt      = 32;

    localparam logic [1:0] c_st_clear    = 2'd0;
    localparam logic [1:0] c_st_run      = 2'd1;
    localparam logic [1:0] c_st_mem_wait = 2'd2;
    localparam logic [1:0] c_st_halt     = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR    = c_st_clear,
        ST_RUN      = c_st_run,
        ST_MEM_WAIT = c_st_mem_wait,
        ST_HALT     = c_st_halt
    } state_e;

endpackage

`default_nettype wire

// File: rtl/stage_sequencer_perf_counter.sv
// ============================================================================
// Module   : perf_counter
// Purpose  : Free-running event counter with enable, synchronous clear, wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/stage_sequencer.sv
// ============================================================================
// Module   : stage_sequencer
// Purpose  : Multi-cycle pipeline stage sequencer with RAM stall, halt/step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES         = c_num_stages_dflt,
    parameter int MEM_STAGE          = c_mem_stage_dflt,
    parameter int RESET_CLEAR_CYCLES = c_reset_clear_cycles_dflt,
    parameter int COUNTER_WIDTH      = c_counter_width_dflt
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          halt_req,
    input  logic                          single_step_mode,
    input  logic                          step,
    input  logic                          mem_access,
    input  logic                          mem_ready,
    output logic [NUM_STAGES-1:0]         stage_wren,
    output logic                          ram_wren,
    output logic                          reg_wren,
    output logic                          state_reset,
    output logic                          halted,
    output logic [$clog2(NUM_STAGES)-1:0] current_stage,
    output logic [COUNTER_WIDTH-1:0]      cycle_count,
    output logic [COUNTER_WIDTH-1:0]      retired_count
);

    localparam int                    c_stage_w   = $clog2(NUM_STAGES);
    localparam logic [c_stage_w-1:0] c_stage_one = c_stage_w'(1);
    localparam logic [c_stage_w-1:0] c_mem_idx   = c_stage_w'(MEM_STAGE);
    localparam logic [c_stage_w-1:0] c_last_idx  = c_stage_w'(NUM_STAGES - 1);
    localparam logic [3:0]           c_clr_last  = 4'(RESET_CLEAR_CYCLES - 1);

    state_e                r_state;
    logic [3:0]            r_clr_cnt;
    logic [c_stage_w-1:0]  r_stage;
    logic                  r_halt_pend;

    logic                  w_mem_stall;
    logic                  w_fire;
    logic                  w_stop;
    logic [NUM_STAGES-1:0] w_onehot;

    assign w_mem_stall = (r_stage == c_mem_idx) && mem_access && !mem_ready;

    // A strobe fires on every productive cycle; reset suppresses it at once so
    // an aborted instruction never writes RAM or the register file.
    assign w_fire = !reset &&
                    (((r_state == ST_RUN) && !w_mem_stall) ||
                     ((r_state == ST_MEM_WAIT) && mem_ready));

    // halt_req may arrive mid-instruction; the pending flag carries it to the boundary.
    assign w_stop = halt_req || single_step_mode || r_halt_pend;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_onehot[i] = (r_stage == c_stage_w'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_stage     <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_stage <= '0;
                    if (r_clr_cnt == c_clr_last) begin
                        r_state   <= ST_RUN;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state     <= ST_MEM_WAIT;
                        r_halt_pend <= r_halt_pend | halt_req;
                    end else if (r_stage == c_last_idx) begin
                        r_stage     <= '0;
                        r_halt_pend <= 1'b0;
                        if (w_stop) begin
                            r_state <= ST_HALT;
                        end
                    end else begin
                        r_stage     <= r_stage + c_stage_one;
                        r_halt_pend <= r_halt_pend | halt_req;
                    end
                end
                ST_MEM_WAIT: begin
                    r_halt_pend <= r_halt_pend | halt_req;
                    if (mem_ready) begin
                        r_state <= ST_RUN;
                        r_stage <= r_stage + c_stage_one;
                    end
                end
                ST_HALT: begin
                    r_stage <= '0;
                    if (step || (!halt_req && !single_step_mode)) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign stage_wren    = w_fire ? w_onehot : '0;
    assign ram_wren      = w_fire && (r_stage == c_mem_idx);
    assign reg_wren      = w_fire && (r_stage == c_last_idx);
    assign state_reset   = reset || (r_state == ST_CLEAR);
    assign halted        = !reset && (r_state == ST_HALT);
    assign current_stage = r_stage;

    perf_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_cycle_cnt (
        .clk      (clk),
        .i_clear  (reset),
        .i_enable ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)),
        .o_count  (cycle_count)
    );

    perf_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_retired_cnt (
        .clk      (clk),
        .i_clear  (reset),
        .i_enable (reg_wren),
        .o_count  (retired_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ============================================================================
// Module   : tb_stage_sequencer
// Purpose  : Directed self-checking bench for stage_sequencer (5 stages, mem 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_sequencer;

    logic        clk;
    logic        r_reset;
    logic        r_halt;
    logic        r_ss;
    logic        r_step;
    logic        r_ma;
    logic        r_mr;

    logic [4:0]  w_sw;
    logic        w_ram;
    logic        w_reg;
    logic        w_srst;
    logic        w_halted;
    logic [2:0]  w_stage;
    logic [31:0] w_cyc;
    logic [31:0] w_ret;

    logic [4:0]  w4_sw;
    logic        w4_ram;
    logic        w4_reg;
    logic        w4_srst;
    logic        w4_halted;
    logic [2:0]  w4_stage;
    logic [3:0]  w4_cyc;
    logic [3:0]  w4_ret;

    int n_checks = 0;
    int n_fail   = 0;

    stage_sequencer #(
        .NUM_STAGES(5), .MEM_STAGE(3), .RESET_CLEAR_CYCLES(2), .COUNTER_WIDTH(32)
    ) dut (
        .clk(clk), .reset(r_reset), .halt_req(r_halt), .single_step_mode(r_ss),
        .step(r_step), .mem_access(r_ma), .mem_ready(r_mr),
        .stage_wren(w_sw), .ram_wren(w_ram), .reg_wren(w_reg),
        .state_reset(w_srst), .halted(w_halted), .current_stage(w_stage),
        .cycle_count(w_cyc), .retired_count(w_ret)
    );

    stage_sequencer #(
        .NUM_STAGES(5), .MEM_STAGE(3), .RESET_CLEAR_CYCLES(2), .COUNTER_WIDTH(4)
    ) dut_w4 (
        .clk(clk), .reset(r_reset), .halt_req(r_halt), .single_step_mode(r_ss),
        .step(r_step), .mem_access(r_ma), .mem_ready(r_mr),
        .stage_wren(w4_sw), .ram_wren(w4_ram), .reg_wren(w4_reg),
        .state_reset(w4_srst), .halted(w4_halted), .current_stage(w4_stage),
        .cycle_count(w4_cyc), .retired_count(w4_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at posedge+1 of "cycle 0", the first cycle with reset low.
    task automatic do_reset();
        @(posedge clk); #1;
        r_reset = 1'b1; r_halt = 1'b0; r_ss = 1'b0; r_step = 1'b0; r_ma = 1'b0; r_mr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        r_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        r_reset = 1'b1; r_halt = 1'b0; r_ss = 1'b0; r_step = 1'b0; r_ma = 1'b0; r_mr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (w_srst !== 1'b1) begin n_fail++; $display("FAIL reset_state_reset got=%b exp=1", w_srst); end
        n_checks++; if (w_sw !== 5'd0) begin n_fail++; $display("FAIL reset_stage_wren got=%b exp=00000", w_sw); end
        n_checks++; if ({w_ram, w_reg, w_halted} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got=%b exp=000", {w_ram, w_reg, w_halted}); end
        n_checks++; if (w_stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage got=%0d exp=0", w_stage); end
        n_checks++; if (w_cyc !== 32'd0 || w_ret !== 32'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", w_cyc, w_ret); end
    endtask

    task automatic test_basic();
        logic [4:0] exp_sw [0:6] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n_checks++; if (w_srst !== (c < 2)) begin n_fail++; $display("FAIL basic_state_reset c=%0d got=%b exp=%b", c, w_srst, (c < 2)); end
            n_checks++; if (w_sw !== exp_sw[c]) begin n_fail++; $display("FAIL basic_wren c=%0d got=%b exp=%b", c, w_sw, exp_sw[c]); end
            n_checks++; if (w_ram !== (c == 5)) begin n_fail++; $display("FAIL basic_ram_wren c=%0d got=%b exp=%b", c, w_ram, (c == 5)); end
            n_checks++; if (w_reg !== (c == 6)) begin n_fail++; $display("FAIL basic_reg_wren c=%0d got=%b exp=%b", c, w_reg, (c == 6)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (w_ret !== 32'd1) begin n_fail++; $display("FAIL basic_retired got=%0d exp=1", w_ret); end
        n_checks++; if (w_cyc !== 32'd5) begin n_fail++; $display("FAIL basic_cycles got=%0d exp=5", w_cyc); end
    endtask

    task automatic test_mem_wait();
        logic [4:0] exp_sw [0:9] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd4, 5'd0, 5'd0, 5'd0, 5'd8, 5'd16};
        logic [2:0] exp_st [0:9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        int ram_cnt = 0;
        do_reset();
        r_ma = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            r_mr = (c >= 8);
            @(negedge clk);
            if (w_ram === 1'b1) ram_cnt++;
            n_checks++; if (w_sw !== exp_sw[c]) begin n_fail++; $display("FAIL memwait_wren c=%0d got=%b exp=%b", c, w_sw, exp_sw[c]); end
            n_checks++; if (w_stage !== exp_st[c]) begin n_fail++; $display("FAIL memwait_stage c=%0d got=%0d exp=%0d", c, w_stage, exp_st[c]); end
            n_checks++; if (w_ram !== (c == 8)) begin n_fail++; $display("FAIL memwait_ram_wren c=%0d got=%b exp=%b", c, w_ram, (c == 8)); end
            @(posedge clk); #1;
        end
        r_ma = 1'b0; r_mr = 1'b0;
        @(negedge clk);
        n_checks++; if (w_cyc !== 32'd8) begin n_fail++; $display("FAIL memwait_cycles got=%0d exp=8", w_cyc); end
        n_checks++; if (w_ret !== 32'd1) begin n_fail++; $display("FAIL memwait_retired got=%0d exp=1", w_ret); end
        n_checks++; if (ram_cnt !== 1) begin n_fail++; $display("FAIL memwait_ram_count got=%0d exp=1", ram_cnt); end
    endtask

    task automatic test_back_to_back();
        int ram_cnt = 0;
        int reg_cnt = 0;
        do_reset();
        r_ma = 1'b1; r_mr = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (w_ram === 1'b1) ram_cnt++;
            if (w_reg === 1'b1) reg_cnt++;
            if (c >= 2) begin
                n_checks++; if (w_sw !== 5'(1 << ((c - 2) % 5))) begin n_fail++; $display("FAIL b2b_wren c=%0d got=%b exp=%b", c, w_sw, 5'(1 << ((c - 2) % 5))); end
            end
            @(posedge clk); #1;
        end
        r_ma = 1'b0; r_mr = 1'b0;
        @(negedge clk);
        n_checks++; if (ram_cnt !== 2 || reg_cnt !== 2) begin n_fail++; $display("FAIL b2b_strobe_count got=%0d/%0d exp=2/2", ram_cnt, reg_cnt); end
        n_checks++; if (w_ret !== 32'd2 || w_cyc !== 32'd10) begin n_fail++; $display("FAIL b2b_counters got=%0d/%0d exp=2/10", w_ret, w_cyc); end
    endtask

    task automatic test_halt();
        logic [4:0] exp_sw [0:17] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd1,
                                      5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
        logic       exp_h  [0:17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            r_halt = (c == 3) || (c >= 9 && c <= 15);
            @(negedge clk);
            n_checks++; if (w_sw !== exp_sw[c]) begin n_fail++; $display("FAIL halt_wren c=%0d got=%b exp=%b", c, w_sw, exp_sw[c]); end
            n_checks++; if (w_halted !== exp_h[c]) begin n_fail++; $display("FAIL halt_halted c=%0d got=%b exp=%b", c, w_halted, exp_h[c]); end
            @(posedge clk); #1;
        end
        r_halt = 1'b0;
    endtask

    task automatic test_single_step();
        do_reset();
        r_ss = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                n_checks++; if (w_sw !== 5'(1 << (c - 2))) begin n_fail++; $display("FAIL sstep_first_wren c=%0d got=%b exp=%b", c, w_sw, 5'(1 << (c - 2))); end
            end
            if (c == 7) begin
                n_checks++; if (w_halted !== 1'b1 || w_ret !== 32'd1) begin n_fail++; $display("FAIL sstep_first_halt got=%b/%0d exp=1/1", w_halted, w_ret); end
            end
            @(posedge clk); #1;
        end
        for (int k = 1; k <= 3; k++) begin
            r_halt = (k == 3);
            repeat (2) begin
                @(negedge clk);
                n_checks++; if (w_halted !== 1'b1 || w_sw !== 5'd0) begin n_fail++; $display("FAIL sstep_idle k=%0d got=%b/%b exp=1/00000", k, w_halted, w_sw); end
                @(posedge clk); #1;
            end
            r_step = 1'b1;
            @(negedge clk);
            n_checks++; if (w_halted !== 1'b1) begin n_fail++; $display("FAIL sstep_step_cycle k=%0d got=%b exp=1", k, w_halted); end
            @(posedge clk); #1;
            r_step = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                n_checks++; if (w_sw !== 5'(1 << i) || w_halted !== 1'b0) begin n_fail++; $display("FAIL sstep_run k=%0d i=%0d got=%b/%b exp=%b/0", k, i, w_sw, w_halted, 5'(1 << i)); end
                @(posedge clk); #1;
            end
            r_halt = 1'b0;
            @(negedge clk);
            n_checks++; if (w_halted !== 1'b1 || w_ret !== 32'(1 + k)) begin n_fail++; $display("FAIL sstep_retired k=%0d got=%b/%0d exp=1/%0d", k, w_halted, w_ret, 1 + k); end
            @(posedge clk); #1;
        end
        r_ss = 1'b0;
    endtask

    task automatic test_reset_mem_wait();
        int ram_cnt = 0;
        do_reset();
        r_ma = 1'b1; r_mr = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            r_reset = (c == 7 || c == 8);
            @(negedge clk);
            if (w_ram === 1'b1) ram_cnt++;
            if (c == 6) begin
                n_checks++; if (w_stage !== 3'd3 || w_sw !== 5'd0) begin n_fail++; $display("FAIL rstwait_stall got=%0d/%b exp=3/00000", w_stage, w_sw); end
            end
            if (c == 8) begin
                n_checks++; if (w_cyc !== 32'd0 || w_ret !== 32'd0) begin n_fail++; $display("FAIL rstwait_counters got=%0d/%0d exp=0/0", w_cyc, w_ret); end
            end
            if (c >= 7 && c <= 10) begin
                n_checks++; if (w_srst !== 1'b1 || w_sw !== 5'd0) begin n_fail++; $display("FAIL rstwait_clear c=%0d got=%b/%b exp=1/00000", c, w_srst, w_sw); end
            end
            if (c == 11) begin
                n_checks++; if (w_srst !== 1'b0 || w_sw !== 5'd1 || w_stage !== 3'd0) begin n_fail++; $display("FAIL rstwait_restart got=%b/%b/%0d exp=0/00001/0", w_srst, w_sw, w_stage); end
            end
            @(posedge clk); #1;
        end
        r_ma = 1'b0;
        n_checks++; if (ram_cnt !== 0) begin n_fail++; $display("FAIL rstwait_ram_count got=%0d exp=0", ram_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (19) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (w4_cyc !== 4'd1) begin n_fail++; $display("FAIL wrap_cycles_w4 got=%0d exp=1", w4_cyc); end
        n_checks++; if (w_cyc !== 32'd17) begin n_fail++; $display("FAIL wrap_cycles_w32 got=%0d exp=17", w_cyc); end
        n_checks++; if (w4_ret !== 4'd3) begin n_fail++; $display("FAIL wrap_retired_w4 got=%0d exp=3", w4_ret); end
    endtask

    initial begin
        r_reset = 1'b1; r_halt = 1'b0; r_ss = 1'b0; r_step = 1'b0; r_ma = 1'b0; r_mr = 1'b0;
        test_reset();
        test_basic();
        test_mem_wait();
        test_back_to_back();
        test_halt();
        test_single_step();
        test_reset_mem_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
